fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 8, width of one FIFO word.
REQ-002 Parameter NUM_REQ, default 4, number of producers sharing the FIFO write port; legal range 2..8.
REQ-003 Parameter MAX_BURST, default 16, maximum words per grant before forced rotation; legal range 1..256.
REQ-004 w_clk  input  1  write-domain clock; the only clock; all logic on rising edge.
REQ-005 w_rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-producer word-valid.
REQ-007 req_last  input  NUM_REQ  per-producer end-of-packet flag, qualified by req_valid.
REQ-008 req_data  input  NUM_REQ*DATAWIDTH  packed producer data; producer i occupies bits [i*DATAWIDTH +: DATAWIDTH].
REQ-009 req_ready  output  NUM_REQ  per-producer word-accepted strobe.
REQ-010 w_full  input  1  FIFO full flag, write domain.
REQ-011 w_en  output  1  FIFO write enable.
REQ-012 w_data  output  DATAWIDTH  FIFO write data.
REQ-013 grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
REQ-014 busy  output  1  high while a grant is held.

Function
REQ-015 FSM states: IDLE, ARB, XFER.
REQ-016 IDLE: grant=0, busy=0, w_en=0, req_ready=0; if any req_valid bit is set, go to ARB next cycle, else stay.
REQ-017 ARB: round-robin selection; the winner is the first set req_valid bit starting at index rr_ptr and wrapping modulo NUM_REQ; register it into grant; go to XFER; burst_cnt=0. If no req_valid bit is set in ARB, return to IDLE.
REQ-018 XFER: busy=1; req_ready[g] = ~w_full; all other req_ready bits = 0.
REQ-019 XFER: w_en = req_valid[g] & ~w_full, combinational; w_data = req_data slice g, combinational (zero-latency path).
REQ-020 A transfer is defined as w_en=1; on each transfer, burst_cnt increments.
REQ-021 Release condition: a transfer with req_last[g]=1, or a transfer with burst_cnt==MAX_BURST-1.
REQ-022 On release: rr_ptr = (g+1) mod NUM_REQ; next state is ARB if any req_valid bit is set in the same cycle, else IDLE.
REQ-023 Minimum gap between grants is one ARB cycle; no word is written in IDLE or ARB.
REQ-024 w_full=1 in XFER: no write, no ready, grant held, burst_cnt unchanged; no timeout.
REQ-025 req_valid[g] drops mid-packet: grant held until a release condition occurs; other producers wait.
REQ-026 req_valid changes on non-granted producers have no effect during XFER.
REQ-027 burst_cnt width is clog2(MAX_BURST)+1; it never wraps because release occurs at MAX_BURST-1.
REQ-028 MAX_BURST=1: every transfer releases, giving strict word-level round-robin.
REQ-029 At most one grant bit and at most one req_ready bit are ever set at a time.

Reset
REQ-030 While w_rst=1 at a w_clk edge: state=IDLE, rr_ptr=0, grant=0, burst_cnt=0.
REQ-031 During and after reset: w_en=0, req_ready=0, busy=0, w_data=0 (w_data forced to 0 outside XFER).
REQ-032 Reset asserted mid-XFER aborts the packet at once; the partial packet is not flushed from the FIFO.

Structure
REQ-033 Shared package fifo_pkg holds the FSM state enum (IDLE, ARB, XFER) and the default DATAWIDTH constant used across the FIFO blocks.
REQ-034 One sub-module, rr_select: combinational round-robin finder taking req_valid and rr_ptr and returning a one-hot winner plus an any flag.
REQ-035 No storage of data words inside this block; the FIFO is the only buffer.

Verification
REQ-036 Reset then req_valid=4'b0101, all req_last=1, w_full=0: grant=4'b0001 in cycle 2, one write of producer 0 data, then ARB, then grant=4'b0100.
REQ-037 Producer 2 holds valid for 20 words with req_last=0 and MAX_BURST=16: exactly 16 writes, release, rr_ptr=3, re-grant to producer 2 after one ARB cycle.
REQ-038 w_full pulsed high for 3 cycles mid-burst: w_en=0 and req_ready=0 during those 3 cycles, grant unchanged, no data lost or duplicated.
REQ-039 All four producers valid with req_last=1 continuously: grants in order 0,1,2,3,0, and each grant is separated by one ARB cycle.
REQ-040 w_rst asserted in the 5th word of a burst: next cycle grant=0, w_en=0, state=IDLE; after release, arbitration restarts from producer 0.
REQ-041 Scoreboard on all tests: the w_data sequence equals the concatenation of accepted producer words, and grant is always one-hot or zero.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks.
package fifo_pkg;

   // Default word width used across the FIFO blocks.
   localparam int FIFO_DATAWIDTH = 8;

   // Write-arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      XFER = 2'd2
   } fifo_arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_select.sv
// Combinational round-robin finder.
// Returns the first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_select #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               any
);

   logic found;

   // Walk the requests starting at rr_ptr and keep the first one seen.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      any    = |req_valid;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
            winner[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants are held per packet (or up to MAX_BURST words); data passes
// straight through from the granted producer to the FIFO with no storage.
module fifo_write_arbiter
   import fifo_pkg::*;
#(
   parameter int DATAWIDTH = FIFO_DATAWIDTH,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                           w_clk,
   input  logic                           w_rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_last,
   input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           w_full,
   output logic                           w_en,
   output logic [DATAWIDTH-1:0]           w_data,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   fifo_arb_state_t       state_q, state_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;

   logic [NUM_REQ-1:0]    winner;
   logic                  any_valid;
   logic [PTR_W-1:0]      g_idx;
   logic [PTR_W-1:0]      next_ptr;
   logic                  own_valid;
   logic                  own_last;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_select (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .winner    (winner),
      .any       (any_valid)
   );

   // Decode the current owner: index, its valid/last, and the pointer after it.
   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) g_idx = PTR_W'(i);
      end
      own_valid = |(req_valid & grant_q);
      own_last  = |(req_last & grant_q);
      next_ptr  = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
   end

   // Zero-latency write path; everything is forced low outside XFER or in reset.
   always_comb begin
      grant     = '0;
      busy      = 1'b0;
      req_ready = '0;
      w_en      = 1'b0;
      w_data    = '0;
      if (!w_rst && state_q == XFER) begin
         grant     = grant_q;
         busy      = 1'b1;
         req_ready = w_full ? '0 : grant_q;
         w_en      = own_valid & ~w_full;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) w_data = req_data[i*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   // Next-state logic: arbitrate, hold grant through the burst, release on last or burst limit.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         IDLE: begin
            if (any_valid) state_d = ARB;
         end
         ARB: begin
            if (any_valid) begin
               grant_d     = winner;
               burst_cnt_d = '0;
               state_d     = XFER;
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
            if (w_en) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
               if (own_last || burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                  rr_ptr_d    = next_ptr;
                  grant_d     = '0;
                  burst_cnt_d = '0;
                  state_d     = any_valid ? ARB : IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state register with synchronous reset.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter with a scoreboard.
module tb_fifo_write_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int MB = 16;

   localparam int P_IDLE = 0;
   localparam int P_ARB  = 1;
   localparam int P_XFER = 2;

   logic              w_clk = 1'b0;
   logic              w_rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_last;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              w_full;
   logic              w_en;
   logic [DW-1:0]     w_data;
   logic [NR-1:0]     grant;
   logic              busy;

   fifo_write_arbiter #(
      .DATAWIDTH (DW),
      .NUM_REQ   (NR),
      .MAX_BURST (MB)
   ) dut (
      .w_clk     (w_clk),
      .w_rst     (w_rst),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .w_full    (w_full),
      .w_en      (w_en),
      .w_data    (w_data),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 w_clk = ~w_clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   // Reference model: who owns the port, how many words it has written, where the search starts.
   int m_phase;
   int m_owner;
   int m_words;
   int m_ptr;

   logic [NR-1:0] e_grant;
   logic [NR-1:0] e_ready;
   logic          e_busy;
   logic          e_wen;
   logic [DW-1:0] e_data;
   logic [DW-1:0] sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int ptr);
      for (int k = 0; k < NR; k++) begin
         if (v[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_owner = -1;
      m_words = 0;
      m_ptr   = 0;
   endtask

   // Expected outputs for the current cycle; accepted words go to the scoreboard.
   task automatic model_eval();
      e_grant = '0;
      e_ready = '0;
      e_busy  = 1'b0;
      e_wen   = 1'b0;
      e_data  = '0;
      if (!w_rst && m_phase == P_XFER) begin
         e_grant[m_owner] = 1'b1;
         e_busy = 1'b1;
         e_ready = w_full ? '0 : e_grant;
         e_wen  = req_valid[m_owner] && !w_full;
         e_data = req_data[m_owner*DW +: DW];
         if (e_wen) sb_q.push_back(e_data);
      end
   endtask

   // Advance the model at the clock edge.
   task automatic model_step();
      if (w_rst) begin
         model_reset();
      end else if (m_phase == P_IDLE) begin
         if (|req_valid) m_phase = P_ARB;
      end else if (m_phase == P_ARB) begin
         int w;
         w = pick(req_valid, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_words = 0;
            m_phase = P_XFER;
         end else begin
            m_phase = P_IDLE;
         end
      end else begin
         if (e_wen) begin
            m_words++;
            if (req_last[m_owner] || m_words == MB) begin
               m_ptr   = (m_owner + 1) % NR;
               m_owner = -1;
               m_phase = (|req_valid) ? P_ARB : P_IDLE;
            end
         end
      end
   endtask

   task automatic step(input logic rst, input logic [NR-1:0] v, input logic [NR-1:0] l,
                       input logic f);
      w_rst     = rst;
      req_valid = v;
      req_last  = l;
      w_full    = f;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'($urandom);
      model_eval();
      @(posedge w_clk);
      model_step();
      #1;
   endtask

   // Monitor: compare outputs mid-cycle and pop the scoreboard on every write.
   always @(negedge w_clk) begin
      if (chk_en) begin
         check("grant", 32'(grant), 32'(e_grant));
         check("busy", 32'(busy), 32'(e_busy));
         check("req_ready", 32'(req_ready), 32'(e_ready));
         check("w_en", 32'(w_en), 32'(e_wen));
         check("w_data", 32'(w_data), 32'(e_data));
         check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
         check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
         if (w_en) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_write", 32'(w_data), 32'hFFFF_FFFF);
            end else begin
               logic [DW-1:0] exp_w;
               exp_w = sb_q.pop_front();
               check("sb_data", 32'(w_data), 32'(exp_w));
            end
         end
      end
   end

   initial begin
      w_rst     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      w_full    = 1'b0;
      model_reset();
      @(posedge w_clk);
      @(posedge w_clk);
      #1;
      chk_en = 1'b1;

      // Reset holds everything quiet even with requests pending.
      for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b1111, 1'b0);

      // Two single-word packets from producers 0 and 2.
      for (int i = 0; i < 8; i++) step(1'b0, 4'b0101, 4'b1111, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, 4'b0000, 1'b0);

      // Long packet from producer 2 hits the burst limit and is re-granted.
      for (int i = 0; i < 40; i++) step(1'b0, 4'b0100, 4'b0000, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, 4'b0000, 1'b0);

      // FIFO full for 3 cycles mid-burst.
      for (int i = 0; i < 6; i++) step(1'b0, 4'b0010, 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, 4'b0000, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 4'b0010, 4'b0000, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, 4'b0000, 1'b0);

      // All producers sending single-word packets: 0,1,2,3,0 order.
      for (int i = 0; i < 14; i++) step(1'b0, 4'b1111, 4'b1111, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, 4'b0000, 1'b0);

      // Reset during the 5th word of a burst, then arbitration restarts at producer 0.
      for (int i = 0; i < 6; i++) step(1'b0, 4'b0010, 4'b0000, 1'b0);
      step(1'b1, 4'b1010, 4'b0000, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 4'b1011, 4'b1111, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, 4'b0000, 1'b0);

      // Random traffic with backpressure and occasional reset.
      for (int i = 0; i < 3000; i++) begin
         logic          r;
         logic [NR-1:0] v;
         logic [NR-1:0] l;
         logic          f;
         r = ($urandom_range(0, 299) == 0);
         v = NR'($urandom);
         for (int j = 0; j < NR; j++) l[j] = ($urandom_range(0, 5) == 0);
         f = ($urandom_range(0, 4) == 0);
         step(r, v, l, f);
      end
      step(1'b1, 4'b0000, 4'b0000, 1'b0);

      chk_en = 1'b0;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
